// File: rtl/transeiver_tx_if.sv
// Engine/UART-side handshake bundle for transeiver_tx.
// The colour-line request signals exist only when TRAX_TX_COLOR_EN is defined.
interface transeiver_tx_if;
  logic        send;
  logic [21:0] move_in;
  logic        tx_done;
  logic        tx_start;
  logic [7:0]  tx_byte;
  logic        busy;
  logic        end_transmit;
  logic        error;
`ifdef TRAX_TX_COLOR_EN
  logic        send_color;
  logic        color;

  modport master (output send, move_in, tx_done, send_color, color,
                  input  tx_start, tx_byte, busy, end_transmit, error);
  modport slave  (input  send, move_in, tx_done, send_color, color,
                  output tx_start, tx_byte, busy, end_transmit, error);
`else
  modport master (output send, move_in, tx_done,
                  input  tx_start, tx_byte, busy, end_transmit, error);
  modport slave  (input  send, move_in, tx_done,
                  output tx_start, tx_byte, busy, end_transmit, error);
`endif
endinterface

// File: rtl/transeiver_tx.sv
// Serialises a binary move into an ASCII line (col letter, decimal row, tile char, newline) fed byte-wise to a UART TX.
// Define TRAX_TX_COLOR_EN to add the colour-line request (dash, W or B, newline).
module transeiver_tx #(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input logic            clock,
  input logic            reset,
  transeiver_tx_if.slave bus
);
  localparam logic [15:0] TMO = TIMEOUT_CYCLES[15:0];

  typedef enum logic [2:0] {S_IDLE, S_CONVERT, S_LOAD, S_WAIT, S_END} state_t;

  state_t      state_q, state_d;
  logic [4:0]  col_q, col_d;
  logic [1:0]  tile_q, tile_d;
  logic [9:0]  rem_q, rem_d;
  logic [3:0]  hund_q, hund_d, tens_q, tens_d, units_q, units_d;
  logic [1:0]  lead_q, lead_d;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] tmo_q, tmo_d;
  logic        tx_start_q, tx_start_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic        busy_q, busy_d;
  logic        end_q, end_d;
  logic        error_q, error_d;
`ifdef TRAX_TX_COLOR_EN
  logic        cmode_q, cmode_d;
  logic        color_q, color_d;
`endif

  logic [7:0]  in_col;
  logic [11:0] in_row;
  logic [1:0]  in_tile;
  logic        move_ok;
  logic [2:0]  ndig, line_len, dsel;
  logic [3:0]  digit;
  logic [7:0]  line_byte;

  assign in_col  = bus.move_in[21:14];
  assign in_row  = bus.move_in[13:2];
  assign in_tile = bus.move_in[1:0];
  assign move_ok = (in_col <= 8'd26) && (in_row <= 12'd999) && (in_tile != 2'd3);

  // Line layout: col, (3 - lead) significant digits, tile, newline.
  always_comb begin
    ndig      = 3'd3 - {1'b0, lead_q};
    line_len  = ndig + 3'd3;
    dsel      = {1'b0, lead_q} + idx_q - 3'd1;
    digit     = (dsel == 3'd0) ? hund_q : (dsel == 3'd1) ? tens_q : units_q;
    line_byte = 8'h0A;
`ifdef TRAX_TX_COLOR_EN
    if (cmode_q) begin
      line_len = 3'd3;
      if (idx_q == 3'd0)      line_byte = 8'h2D;
      else if (idx_q == 3'd1) line_byte = color_q ? 8'h42 : 8'h57;
    end else
`endif
    if (idx_q == 3'd0) begin
      line_byte = 8'h40 + {3'b000, col_q};
    end else if (idx_q <= ndig) begin
      line_byte = 8'h30 + {4'h0, digit};
    end else if (idx_q == ndig + 3'd1) begin
      line_byte = (tile_q == 2'd0) ? 8'h2B : (tile_q == 2'd1) ? 8'h2F : 8'h5C;
    end
  end

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    tile_d     = tile_q;
    rem_d      = rem_q;
    hund_d     = hund_q;
    tens_d     = tens_q;
    units_d    = units_q;
    lead_d     = lead_q;
    idx_d      = idx_q;
    tmo_d      = tmo_q;
    tx_byte_d  = tx_byte_q;
    busy_d     = busy_q;
    tx_start_d = 1'b0;
    end_d      = 1'b0;
    error_d    = 1'b0;
`ifdef TRAX_TX_COLOR_EN
    cmode_d    = cmode_q;
    color_d    = color_q;
`endif
    case (state_q)
      S_IDLE: begin
        idx_d = 3'd0;
`ifdef TRAX_TX_COLOR_EN
        if (bus.send_color) begin
          cmode_d = 1'b1;
          color_d = bus.color;
          busy_d  = 1'b1;
          state_d = S_LOAD;
        end else
`endif
        if (bus.send) begin
          if (move_ok) begin
            col_d   = in_col[4:0];
            tile_d  = in_tile;
            rem_d   = in_row[9:0];
            hund_d  = 4'd0;
            tens_d  = 4'd0;
            busy_d  = 1'b1;
            state_d = S_CONVERT;
`ifdef TRAX_TX_COLOR_EN
            cmode_d = 1'b0;
`endif
          end else begin
            error_d = 1'b1;
          end
        end
      end
      S_CONVERT: begin
        if (rem_q >= 10'd100) begin
          rem_d  = rem_q - 10'd100;
          hund_d = hund_q + 4'd1;
        end else if (rem_q >= 10'd10) begin
          rem_d  = rem_q - 10'd10;
          tens_d = tens_q + 4'd1;
        end else begin
          units_d = rem_q[3:0];
          lead_d  = (hund_q != 4'd0) ? 2'd0 : (tens_q != 4'd0) ? 2'd1 : 2'd2;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        tx_byte_d  = line_byte;
        tx_start_d = 1'b1;
        tmo_d      = 16'd0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (bus.tx_done) begin
          if (idx_q == line_len - 3'd1) begin
            state_d = S_END;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = S_LOAD;
          end
        end else if (TMO != 16'd0) begin
          // UART never acknowledged: abandon the rest of the line.
          tmo_d = tmo_q + 16'd1;
          if (tmo_d == TMO) begin
            error_d = 1'b1;
            busy_d  = 1'b0;
            idx_d   = 3'd0;
            state_d = S_IDLE;
          end
        end
      end
      S_END: begin
        end_d   = 1'b1;
        busy_d  = 1'b0;
        idx_d   = 3'd0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      col_q      <= 5'd0;
      tile_q     <= 2'd0;
      rem_q      <= 10'd0;
      hund_q     <= 4'd0;
      tens_q     <= 4'd0;
      units_q    <= 4'd0;
      lead_q     <= 2'd0;
      idx_q      <= 3'd0;
      tmo_q      <= 16'd0;
      tx_start_q <= 1'b0;
      tx_byte_q  <= 8'h00;
      busy_q     <= 1'b0;
      end_q      <= 1'b0;
      error_q    <= 1'b0;
`ifdef TRAX_TX_COLOR_EN
      cmode_q    <= 1'b0;
      color_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      tile_q     <= tile_d;
      rem_q      <= rem_d;
      hund_q     <= hund_d;
      tens_q     <= tens_d;
      units_q    <= units_d;
      lead_q     <= lead_d;
      idx_q      <= idx_d;
      tmo_q      <= tmo_d;
      tx_start_q <= tx_start_d;
      tx_byte_q  <= tx_byte_d;
      busy_q     <= busy_d;
      end_q      <= end_d;
      error_q    <= error_d;
`ifdef TRAX_TX_COLOR_EN
      cmode_q    <= cmode_d;
      color_q    <= color_d;
`endif
    end
  end

  assign bus.tx_start     = tx_start_q;
  assign bus.tx_byte      = tx_byte_q;
  assign bus.busy         = busy_q;
  assign bus.end_transmit = end_q;
  assign bus.error        = error_q;
endmodule
